// File: rtl/pipe_issue_control.sv
// Scoreboarded issue controller for the PMIPS-L pipeline: per-register write-pending counters plus a post-BEQ wait.
// Optional StallCount port and counter are compiled in with CTRL_STALL_CNT_EN.
module pipe_issue_control #(
   parameter int PIPE_DEPTH = 3,
   parameter int BR_STALLS  = 3
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [15:0] Instruction,
   output logic        PCStall,
   output logic        RegWrite,
   output logic        RegDst,
   output logic        ALUSrc,
   output logic        Branch,
   output logic        MemWrite,
   output logic        MemRead,
   output logic        MemtoReg,
   output logic [1:0]  ALUOp
`ifdef CTRL_STALL_CNT_EN
   ,
   output logic [15:0] StallCount
`endif
);

   localparam logic [1:0] ST_RESET = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_BWAIT = 2'd2;

   localparam logic [2:0] DEPTH_L = 3'(PIPE_DEPTH);
   localparam logic [2:0] BR_L    = 3'(BR_STALLS);

   logic [2:0] opcode, rs, rt, rd;
   logic       unused_funct;

   assign opcode       = Instruction[15:13];
   assign rs           = Instruction[12:10];
   assign rt           = Instruction[9:7];
   assign rd           = Instruction[6:4];
   assign unused_funct = ^Instruction[3:0];

   logic [1:0]      state_q, state_d;
   logic [2:0]      wait_q, wait_d;
   logic [7:0][2:0] sb_q, sb_d;

   // Decode of the IF/ID instruction, independent of whether it issues.
   logic       d_regwrite, d_regdst, d_alusrc, d_branch, d_memwrite, d_memread, d_memtoreg;
   logic [1:0] d_aluop;
   logic       use_rs, use_rt;
   logic [2:0] dest;

   always_comb begin
      d_regwrite = 1'b0;
      d_regdst   = 1'b0;
      d_alusrc   = 1'b0;
      d_branch   = 1'b0;
      d_memwrite = 1'b0;
      d_memread  = 1'b0;
      d_memtoreg = 1'b0;
      d_aluop    = 2'd0;
      use_rs     = 1'b0;
      use_rt     = 1'b0;
      dest       = rt;
      case (opcode)
         3'd0: begin
            d_regwrite = 1'b1;
            d_regdst   = 1'b1;
            d_aluop    = 2'd2;
            use_rs     = 1'b1;
            use_rt     = 1'b1;
            dest       = rd;
         end
         3'd2: begin
            d_aluop  = 2'd1;
            d_branch = 1'b1;
            use_rs   = 1'b1;
            use_rt   = 1'b1;
         end
         3'd3: begin
            d_regwrite = 1'b1;
            d_alusrc   = 1'b1;
            use_rs     = 1'b1;
         end
         3'd5: begin
            d_regwrite = 1'b1;
            d_alusrc   = 1'b1;
            d_memread  = 1'b1;
            d_memtoreg = 1'b1;
            use_rs     = 1'b1;
         end
         3'd6: begin
            d_alusrc   = 1'b1;
            d_memwrite = 1'b1;
            use_rs     = 1'b1;
            use_rt     = 1'b1;
         end
         default: ;
      endcase
   end

   logic hazard, issue;

   assign hazard = (use_rs && (rs != 3'd0) && (sb_q[rs] != 3'd0)) ||
                   (use_rt && (rt != 3'd0) && (sb_q[rt] != 3'd0));
   assign issue  = (state_q == ST_RUN) && !hazard;

   assign PCStall  = !issue;
   assign RegWrite = issue & d_regwrite;
   assign RegDst   = issue & d_regdst;
   assign ALUSrc   = issue & d_alusrc;
   assign Branch   = issue & d_branch;
   assign MemWrite = issue & d_memwrite;
   assign MemRead  = issue & d_memread;
   assign MemtoReg = issue & d_memtoreg;
   assign ALUOp    = issue ? d_aluop : 2'd0;

   always_comb begin
      state_d = state_q;
      wait_d  = wait_q;
      case (state_q)
         ST_RESET: state_d = ST_RUN;
         ST_RUN: begin
            if (issue && d_branch && (BR_STALLS != 0)) begin
               state_d = ST_BWAIT;
               wait_d  = BR_L;
            end
         end
         ST_BWAIT: begin
            wait_d = wait_q - 3'd1;
            if (wait_q <= 3'd1) state_d = ST_RUN;
         end
         default: state_d = ST_RESET;
      endcase
   end

   // A fresh load for the issuing writer wins over that register's decrement.
   always_comb begin
      for (int i = 0; i < 8; i++)
         sb_d[i] = (sb_q[i] != 3'd0) ? sb_q[i] - 3'd1 : 3'd0;
      if (issue && d_regwrite && (dest != 3'd0))
         sb_d[dest] = DEPTH_L;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= ST_RESET;
         wait_q  <= 3'd0;
         sb_q    <= '0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         sb_q    <= sb_d;
      end
   end

`ifdef CTRL_STALL_CNT_EN
   logic [15:0] stall_cnt_q, stall_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (PCStall && (state_q != ST_RESET) && (stall_cnt_q != 16'hFFFF))
         stall_cnt_d = stall_cnt_q + 16'd1;
   end

   always_ff @(posedge clock) begin
      if (reset) stall_cnt_q <= 16'd0;
      else       stall_cnt_q <= stall_cnt_d;
   end

   assign StallCount = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_issue_control.sv
// Self-checking bench for pipe_issue_control: per-cycle vector table through an expected-value queue,
// plus a short sequence on a second instance built with BR_STALLS=0.
module tb_pipe_issue_control;

   logic        clock;
   logic        reset;
   logic [15:0] Instruction;

   logic       a_stall, a_rw, a_rd, a_as, a_br, a_mw, a_mr, a_m2r;
   logic [1:0] a_op;
   logic       b_stall, b_rw, b_rd, b_as, b_br, b_mw, b_mr, b_m2r;
   logic [1:0] b_op;
`ifdef CTRL_STALL_CNT_EN
   logic [15:0] a_sc, b_sc;
`endif

   pipe_issue_control #(.PIPE_DEPTH(3), .BR_STALLS(3)) dut_a (
      .clock(clock), .reset(reset), .Instruction(Instruction),
      .PCStall(a_stall), .RegWrite(a_rw), .RegDst(a_rd), .ALUSrc(a_as), .Branch(a_br),
      .MemWrite(a_mw), .MemRead(a_mr), .MemtoReg(a_m2r), .ALUOp(a_op)
`ifdef CTRL_STALL_CNT_EN
      , .StallCount(a_sc)
`endif
   );

   pipe_issue_control #(.PIPE_DEPTH(3), .BR_STALLS(0)) dut_b (
      .clock(clock), .reset(reset), .Instruction(Instruction),
      .PCStall(b_stall), .RegWrite(b_rw), .RegDst(b_rd), .ALUSrc(b_as), .Branch(b_br),
      .MemWrite(b_mw), .MemRead(b_mr), .MemtoReg(b_m2r), .ALUOp(b_op)
`ifdef CTRL_STALL_CNT_EN
      , .StallCount(b_sc)
`endif
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // {RegWrite, RegDst, ALUSrc, ALUOp, Branch, MemWrite, MemRead, MemtoReg}
   localparam logic [8:0] C_BUB  = 9'b000000000;
   localparam logic [8:0] C_R    = 9'b110100000;
   localparam logic [8:0] C_BEQ  = 9'b000011000;
   localparam logic [8:0] C_ADDI = 9'b101000000;
   localparam logic [8:0] C_LW   = 9'b101000011;
   localparam logic [8:0] C_SW   = 9'b001000100;

   typedef struct {
      logic        rst;
      logic [15:0] ins;
      logic        stall;
      logic [8:0]  ctrl;
      logic        chk_sc;
      logic [15:0] sc;
   } vec_t;

   vec_t tbl[$];
   vec_t expq[$];
   int   checks = 0;
   int   errors = 0;

   function automatic logic [15:0] i_addi(int rt, int rs, int imm);
      return {3'd3, 3'(rs), 3'(rt), 7'(imm)};
   endfunction
   function automatic logic [15:0] i_add(int rd, int rs, int rt);
      return {3'd0, 3'(rs), 3'(rt), 3'(rd), 4'd0};
   endfunction
   function automatic logic [15:0] i_beq(int rs, int rt);
      return {3'd2, 3'(rs), 3'(rt), 7'd0};
   endfunction
   function automatic logic [15:0] i_lw(int rt, int rs);
      return {3'd5, 3'(rs), 3'(rt), 7'd0};
   endfunction
   function automatic logic [15:0] i_sw(int rt, int rs);
      return {3'd6, 3'(rs), 3'(rt), 7'd0};
   endfunction
   function automatic logic [15:0] i_nop(int op);
      return {3'(op), 13'd0};
   endfunction

   function automatic void add(logic rst, logic [15:0] ins, logic stall, logic [8:0] ctrl,
                               logic chk_sc = 1'b0, logic [15:0] sc = 16'd0);
      vec_t v;
      v.rst = rst; v.ins = ins; v.stall = stall; v.ctrl = ctrl; v.chk_sc = chk_sc; v.sc = sc;
      tbl.push_back(v);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic step(input logic rst, input logic [15:0] ins);
      @(posedge clock);
      #1;
      reset       = rst;
      Instruction = ins;
   endtask

   initial begin
      vec_t e;
      reset       = 1'b1;
      Instruction = i_addi(1, 0, 5);

      // reset held two edges, then one RESET cycle, then addi issues
      add(1, i_addi(1, 0, 5), 1, C_BUB);
      add(0, i_addi(1, 0, 5), 1, C_BUB, 1, 16'd0);
      add(0, i_addi(1, 0, 5), 0, C_ADDI);
      // back-to-back RAW on r1: three bubbles
      add(0, i_add(2, 1, 1), 1, C_BUB);
      add(0, i_add(2, 1, 1), 1, C_BUB);
      add(0, i_add(2, 1, 1), 1, C_BUB);
      add(0, i_add(2, 1, 1), 0, C_R, 1, 16'd3);
      // independent stream
      add(0, i_addi(3, 0, 1), 0, C_ADDI);
      add(0, i_addi(4, 0, 2), 0, C_ADDI);
      add(0, i_sw(6, 7), 0, C_SW);
      // BEQ followed by three wait bubbles
      add(0, i_beq(0, 0), 0, C_BEQ);
      add(0, i_addi(7, 0, 1), 1, C_BUB);
      add(0, i_addi(7, 0, 1), 1, C_BUB);
      add(0, i_addi(7, 0, 1), 1, C_BUB);
      add(0, i_addi(7, 0, 1), 0, C_ADDI, 1, 16'd6);
      // r0 is never pending; r5 load-use stalls
      add(0, i_lw(0, 1), 0, C_LW);
      add(0, i_add(3, 0, 0), 0, C_R);
      add(0, i_lw(5, 0), 0, C_LW);
      add(0, i_sw(5, 0), 1, C_BUB);
      add(0, i_sw(5, 0), 1, C_BUB);
      add(0, i_sw(5, 0), 1, C_BUB);
      add(0, i_sw(5, 0), 0, C_SW, 1, 16'd9);
      add(0, i_nop(7), 0, C_BUB);
      // reset asserted during the second hazard bubble
      add(0, i_addi(6, 0, 1), 0, C_ADDI);
      add(0, i_add(1, 6, 6), 1, C_BUB);
      add(1, i_add(1, 6, 6), 1, C_BUB);
      add(0, i_add(1, 6, 6), 1, C_BUB, 1, 16'd0);
      add(0, i_add(1, 6, 6), 0, C_R);
      // hazarded BEQ does not start the branch wait until it actually issues
      add(0, i_addi(2, 0, 1), 0, C_ADDI);
      add(0, i_beq(2, 0), 1, C_BUB);
      add(0, i_beq(2, 0), 1, C_BUB);
      add(0, i_beq(2, 0), 1, C_BUB);
      add(0, i_beq(2, 0), 0, C_BEQ);
      add(0, i_nop(1), 1, C_BUB);
      add(0, i_nop(1), 1, C_BUB);
      add(0, i_nop(1), 1, C_BUB);
      add(0, i_nop(1), 0, C_BUB, 1, 16'd6);

      for (int i = 0; i < tbl.size(); i++) begin
         step(tbl[i].rst, tbl[i].ins);
         expq.push_back(tbl[i]);
         @(negedge clock);
         e = expq.pop_front();
         chk($sformatf("row%0d_stall", i), {31'd0, a_stall}, {31'd0, e.stall});
         chk($sformatf("row%0d_ctrl", i),
             {23'd0, a_rw, a_rd, a_as, a_op, a_br, a_mw, a_mr, a_m2r}, {23'd0, e.ctrl});
`ifdef CTRL_STALL_CNT_EN
         if (e.chk_sc) chk($sformatf("row%0d_stallcount", i), {16'd0, a_sc}, {16'd0, e.sc});
`endif
      end

      // BR_STALLS=0 instance: BEQ inserts no bubble
      step(1, i_nop(7));
      step(1, i_nop(7));
      step(0, i_nop(7));
      @(negedge clock);
      chk("b_reset_stall", {31'd0, b_stall}, 32'd1);
      chk("b_reset_ctrl", {23'd0, b_rw, b_rd, b_as, b_op, b_br, b_mw, b_mr, b_m2r}, 32'd0);
      step(0, i_beq(0, 0));
      @(negedge clock);
      chk("b_beq_ctrl", {22'd0, b_stall, b_rw, b_rd, b_as, b_op, b_br, b_mw, b_mr, b_m2r},
          {22'd0, 1'b0, C_BEQ});
      step(0, i_addi(1, 0, 1));
      @(negedge clock);
      chk("b_after_beq", {22'd0, b_stall, b_rw, b_rd, b_as, b_op, b_br, b_mw, b_mr, b_m2r},
          {22'd0, 1'b0, C_ADDI});
      chk("a_after_beq_stall", {31'd0, a_stall}, 32'd1);
      step(0, i_add(2, 1, 1));
      @(negedge clock);
      chk("b_raw_stall", {31'd0, b_stall}, 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
